// File: rtl/noc_vc_credit_scheduler.sv
// Purpose: shares one credit-flow-controlled NoC injection port between VC_W
//          virtual-channel requesters, with a round-robin grant and one credit
//          counter per VC.
// Latency: a transfer in cycle N shows on credit_vc_target/credit_packet in N+1.
//          A credit return in N makes the VC eligible in N+1.
// Backpressure: req_ready is high only for the round-robin winner among the VCs
//          that are valid and hold a credit. It is low while rst is asserted.
// Ports:
//   clk, rst               clock and asynchronous active-high reset
//   req_valid/req_packet   per-VC requests; VC i uses req_packet[i*P_W +: P_W]
//   req_ready              one-hot accept to the winning VC
//   credit_vc_target       registered one-hot VC of the injected packet (0 = idle)
//   credit_packet          registered injected packet
//   credit_vc_credit_gnt   per-VC credit return pulses
//   credit_err             sticky: a credit was returned to a VC that was already full
//   sent_count             injected packet count
// Optional feature: define NOC_VC_SCHED_STATS_EN to build the sent_count counter.
//   Without it, sent_count is tied to zero.

module noc_vc_credit_scheduler #(
    parameter int VC_W    = 2,
    parameter int A_W     = 8,
    parameter int D_W     = 32,
    parameter int CREDITS = 4,
    localparam int P_W    = A_W + D_W,
    localparam int C_W    = $clog2(CREDITS + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [VC_W-1:0]     req_valid,
    input  logic [VC_W*P_W-1:0] req_packet,
    output logic [VC_W-1:0]     req_ready,
    output logic [VC_W-1:0]     credit_vc_target,
    output logic [P_W-1:0]      credit_packet,
    input  logic [VC_W-1:0]     credit_vc_credit_gnt,
    output logic                credit_err,
    output logic [15:0]         sent_count
);

    localparam int LAST_W = (VC_W > 1) ? $clog2(VC_W) : 1;
    localparam logic [C_W-1:0] CNT_MAX = C_W'(CREDITS);

    logic [C_W-1:0]    credit_cnt_q [VC_W];
    logic [C_W-1:0]    credit_cnt_d [VC_W];
    logic [LAST_W-1:0] last_q, last_d;
    logic [VC_W-1:0]   credit_vc_target_q, credit_vc_target_d;
    logic [P_W-1:0]    credit_packet_q, credit_packet_d;
    logic              credit_err_q, credit_err_d;

    logic [VC_W-1:0]   eligible;
    logic [VC_W-1:0]   grant;
    logic [VC_W-1:0]   err_set;
    logic [LAST_W-1:0] win_idx;
    logic [LAST_W-1:0] idx;
    logic              found;
    logic [P_W-1:0]    pkt_sel;

    // Eligibility is masked by rst so nothing is accepted while the counters are
    // held in reset.
    for (genvar i = 0; i < VC_W; i++) begin : g_vc
        assign eligible[i] = req_valid[i] && (credit_cnt_q[i] != '0) && !rst;

        // Send and return together cancel out. A return to a full counter with
        // no send would overflow, so the counter saturates and flags an error.
        always_comb begin
            credit_cnt_d[i] = credit_cnt_q[i];
            err_set[i]      = 1'b0;
            case ({grant[i], credit_vc_credit_gnt[i]})
                2'b10: credit_cnt_d[i] = credit_cnt_q[i] - C_W'(1);
                2'b01: begin
                    if (credit_cnt_q[i] == CNT_MAX) begin
                        err_set[i] = 1'b1;
                    end else begin
                        credit_cnt_d[i] = credit_cnt_q[i] + C_W'(1);
                    end
                end
                default: credit_cnt_d[i] = credit_cnt_q[i];
            endcase
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                credit_cnt_q[i] <= CNT_MAX;
            end else begin
                credit_cnt_q[i] <= credit_cnt_d[i];
            end
        end
    end

    // Round-robin search from last+1, wrapping. The first eligible VC found wins.
    always_comb begin
        grant   = '0;
        win_idx = last_q;
        found   = 1'b0;
        idx     = '0;
        for (int k = 1; k <= VC_W; k++) begin
            idx = LAST_W'((int'(last_q) + k) % VC_W);
            if (!found && eligible[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                win_idx    = idx;
            end
        end
    end

    assign req_ready = grant;

    // The grant is one-hot, so an AND-OR mux is enough.
    always_comb begin
        pkt_sel = '0;
        for (int i = 0; i < VC_W; i++) begin
            if (grant[i]) begin
                pkt_sel = pkt_sel | req_packet[i*P_W +: P_W];
            end
        end
    end

    always_comb begin
        credit_vc_target_d = grant;
        credit_packet_d    = found ? pkt_sel : credit_packet_q;
        last_d             = found ? win_idx : last_q;
        credit_err_d       = credit_err_q | (|err_set);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q             <= LAST_W'(VC_W - 1);
            credit_vc_target_q <= '0;
            credit_packet_q    <= '0;
            credit_err_q       <= 1'b0;
        end else begin
            last_q             <= last_d;
            credit_vc_target_q <= credit_vc_target_d;
            credit_packet_q    <= credit_packet_d;
            credit_err_q       <= credit_err_d;
        end
    end

    assign credit_vc_target = credit_vc_target_q;
    assign credit_packet    = credit_packet_q;
    assign credit_err       = credit_err_q;

`ifdef NOC_VC_SCHED_STATS_EN
    logic [15:0] sent_count_q, sent_count_d;

    // Wraps naturally from 16'hFFFF to 0.
    always_comb begin
        sent_count_d = found ? sent_count_q + 16'd1 : sent_count_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sent_count_q <= 16'h0000;
        end else begin
            sent_count_q <= sent_count_d;
        end
    end

    assign sent_count = sent_count_q;
`else
    assign sent_count = 16'h0000;
`endif

endmodule
